acc_row_drain: RTL and testbench
================================

Name: acc_row_drain

Overview:
- Output stage directly downstream of the systolic accumulator (`pe`).
- Captures the accumulator's N x N result matrix in one cycle, then streams it out one row (N elements) per handshake over a valid/ready interface.
- Issues a one-cycle clear pulse back to the accumulator on capture, so the next tile can start accumulating while this one drains.

Parameters:
- N, 4, matrix dimension (rows = columns); legal range N >= 2.
- NUM_BITS, 16, width of each matrix element.
- IDX_W, $clog2(N), width of the row index output; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- mat_i  input  [NUM_BITS-1:0] x [N][N]  accumulated result matrix from the accumulator.
- mat_valid_i  input  1  mat_i holds a complete tile.
- mat_ready_o  output  1  block can capture a tile.
- acc_clr_o  output  1  one-cycle pulse telling the accumulator to zero its array.
- row_o  output  [NUM_BITS-1:0] x [N]  current output row.
- row_idx_o  output  IDX_W  index of the row on row_o.
- row_valid_o  output  1  row_o / row_idx_o are valid.
- row_ready_i  input  1  consumer accepts the row.
- row_last_o  output  1  row_o is row N-1 of the tile.
- busy_o  output  1  a tile is held (FSM is in DRAIN).

Behaviour:
- Reset values, applied immediately on rst_i assertion regardless of the clock:
  - FSM = IDLE; matrix buffer = 0; row counter = 0.
  - row_o = 0, row_idx_o = 0, row_valid_o = 0, row_last_o = 0, acc_clr_o = 0, busy_o = 0.
  - mat_ready_o = 1 as soon as rst_i deasserts.
- FSM has two states, IDLE and DRAIN.
- IDLE:
  - mat_ready_o = 1, row_valid_o = 0.
  - On mat_valid_i = 1: register mat_i into the buffer, set counter = 0, pulse acc_clr_o for exactly the next cycle, go to DRAIN.
- DRAIN:
  - mat_ready_o = 0; mat_valid_i is ignored.
  - row_o = buffer[counter], row_idx_o = counter, row_valid_o = 1, busy_o = 1.
  - row_o and row_idx_o are driven directly from registers, with no combinational path from row_ready_i.
  - row_last_o = 1 iff counter == N-1.
- A row transfer occurs on a cycle with row_valid_o && row_ready_i.
  - Transfer with counter < N-1: counter increments, and the next row appears the following cycle.
  - Transfer with counter == N-1: go to IDLE; counter wraps to 0; row_valid_o = 0 the following cycle.
- Stall: while row_valid_o = 1 and row_ready_i = 0, row_o, row_idx_o and row_last_o hold stable.
- Latency and throughput:
  - Capture edge to first row_valid_o: 1 cycle.
  - With row_ready_i held high, rows stream at 1 per cycle, so a tile drains in N cycles.
  - One idle bubble between tiles: mat_ready_o rises the cycle after the last transfer.
- No arithmetic is performed: elements pass through bit-exact, NUM_BITS wide.
- Reset mid-drain: the tile is discarded, no further rows are emitted, and acc_clr_o is not pulsed.
- row_ready_i high while row_valid_o = 0 has no effect.

Optional Feature:
- Macro: DRAIN_TRANSPOSE_EN.
- When defined:
  - Row k presented on row_o is column k of the captured tile, i.e. row_o[j] = mat[j][k].
  - row_idx_o carries the column index.
  - All handshake, timing and last-flag behaviour is unchanged.
- When undefined: row k is mat[k][*]; no transpose mux is synthesized.

Test Plan:
- Basic drain:
  - Stimulus: reset, then release; capture mat[i][j] = 16*i + j (N = 4, NUM_BITS = 16) with row_ready_i = 1.
  - Required response: rows {0,1,2,3}, {16,17,18,19}, {32..35}, {48..51} on 4 consecutive cycles, starting 1 cycle after capture; row_last_o = 1 only on idx 3; acc_clr_o high exactly 1 cycle.
- Backpressure:
  - Stimulus: same tile; hold row_ready_i = 0 for 3 cycles at idx 1.
  - Required response: row_o stays {16,17,18,19} and row_idx_o stays 1 throughout the stall; no row is skipped or duplicated after release.
- Back-to-back tiles:
  - Stimulus: mat_valid_i held high with a second tile of all 0xFFFF.
  - Required response: mat_ready_o = 0 during the drain; second tile is captured the cycle after the idx-3 transfer; its rows all read 0xFFFF.
- Capture ignored while draining:
  - Stimulus: change mat_i mid-drain.
  - Required response: output rows still match the originally captured tile.
- Async reset mid-drain:
  - Stimulus: assert rst_i between clock edges at idx 2.
  - Required response: row_valid_o = 0, busy_o = 0, row_o = 0 before the next edge; mat_ready_o = 1 after release.
- Transpose build (DRAIN_TRANSPOSE_EN defined):
  - Stimulus: the basic-drain tile.
  - Required response: first row = {0,16,32,48}, last row = {3,19,35,51}.

Source files
------------

// File: rtl/acc_row_drain_if.sv
// acc_row_drain_if: tile capture and row stream signals between accumulator, drain stage and consumer
interface acc_row_drain_if #(
  parameter int N        = 4,
  parameter int NUM_BITS = 16
);
  localparam int IDX_W = $clog2(N);
  logic [N-1:0][N-1:0][NUM_BITS-1:0] mat_i;
  logic                              mat_valid_i;
  logic                              mat_ready_o;
  logic                              acc_clr_o;
  logic [N-1:0][NUM_BITS-1:0]        row_o;
  logic [IDX_W-1:0]                  row_idx_o;
  logic                              row_valid_o;
  logic                              row_ready_i;
  logic                              row_last_o;
  logic                              busy_o;
  modport slave (
    input  mat_i, mat_valid_i, row_ready_i,
    output mat_ready_o, acc_clr_o, row_o, row_idx_o, row_valid_o, row_last_o, busy_o
  );
  modport master (
    output mat_i, mat_valid_i, row_ready_i,
    input  mat_ready_o, acc_clr_o, row_o, row_idx_o, row_valid_o, row_last_o, busy_o
  );
endinterface

// File: rtl/acc_row_drain.sv
// acc_row_drain: captures an NxN tile in one cycle and streams it out one row per handshake; DRAIN_TRANSPOSE_EN streams columns instead
module acc_row_drain #(
  parameter int N        = 4,
  parameter int NUM_BITS = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  acc_row_drain_if.slave bus
);
  localparam int IDX_W = $clog2(N);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  logic [0:0]                        state_q, state_d;
  logic [N-1:0][N-1:0][NUM_BITS-1:0] tile_q, tile_d;
  logic [IDX_W-1:0]                  cnt_q, cnt_d;
  logic                              clr_q, clr_d;
  logic                              capture, xfer;
  logic [N-1:0][NUM_BITS-1:0]        row;
  // capture a tile while idle, advance one row per accepted transfer while draining
  always_comb begin
    capture = state_q == IDLE && bus.mat_valid_i;
    xfer    = state_q == DRAIN && bus.row_ready_i;
    tile_d  = capture ? bus.mat_i : tile_q;
    clr_d   = capture;
    cnt_d   = capture ? '0 : xfer ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
    state_d = capture ? DRAIN : (xfer && cnt_q == LAST) ? IDLE : state_q;
  end
`ifdef DRAIN_TRANSPOSE_EN
  // present column cnt_q of the held tile: element j comes from row j
  always_comb begin
    for (int j = 0; j < N; j++) row[j] = tile_q[j][cnt_q];
  end
`else
  // present row cnt_q of the held tile
  always_comb begin
    row = tile_q[cnt_q];
  end
`endif
  // state registers; reset discards any held tile
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tile_q  <= '0;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
    end
  end
  assign bus.row_o       = row;
  assign bus.row_idx_o   = cnt_q;
  assign bus.row_valid_o = state_q == DRAIN;
  assign bus.busy_o      = state_q == DRAIN;
  assign bus.row_last_o  = state_q == DRAIN && cnt_q == LAST;
  assign bus.mat_ready_o = state_q == IDLE;
  assign bus.acc_clr_o   = clr_q;
endmodule

// File: tb/tb_acc_row_drain.sv
// tb_acc_row_drain: table-driven per-cycle checks of capture, drain, stall, back-to-back tiles, plus async reset mid-drain
module tb_acc_row_drain;
  localparam int N = 4;
  localparam int W = 16;
  typedef struct packed {
    logic       mv;
    logic [1:0] mt;
    logic       rdy;
    logic       mrdy;
    logic       clr;
    logic       v;
    logic [1:0] idx;
    logic       last;
    logic       et;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tbl [26];
  acc_row_drain_if #(.N(N), .NUM_BITS(W)) bus ();
  acc_row_drain #(.N(N), .NUM_BITS(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t mk(int mv, int mt, int rdy, int mrdy, int clr, int v, int idx, int last, int et);
    vec_t r;
    r.mv = 1'(mv); r.mt = 2'(mt); r.rdy = 1'(rdy); r.mrdy = 1'(mrdy); r.clr = 1'(clr);
    r.v = 1'(v); r.idx = 2'(idx); r.last = 1'(last); r.et = 1'(et);
    return r;
  endfunction
  // tile 0: 16*i+j, tile 1: all ones, tile 2: junk used to disturb mat_i mid-drain
  function automatic logic [W-1:0] elem(int t, int i, int j);
    return t == 0 ? W'(16 * i + j) : t == 1 ? 16'hFFFF : 16'hA5A5 ^ W'(i * 4 + j);
  endfunction
  function automatic logic [N*W-1:0] exp_row(int t, int k);
    logic [N*W-1:0] r;
    for (int j = 0; j < N; j++)
`ifdef DRAIN_TRANSPOSE_EN
      r[j*W +: W] = elem(t, j, k);
`else
      r[j*W +: W] = elem(t, k, j);
`endif
    return r;
  endfunction
  task automatic set_mat(int t);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) bus.mat_i[i][j] = elem(t, i, j);
  endtask
  task automatic chk(string nm, logic [N*W-1:0] got, logic [N*W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    // basic drain
    tbl[0]  = mk(1, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 1, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 0, 1, 1, 0, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0, 1, 2, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0, 1, 3, 1, 0);
    tbl[5]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0);
    // backpressure at idx 1 while mat_i is disturbed and mat_valid_i pulses during the drain
    tbl[6]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 2, 1, 0, 1, 1, 0, 0, 0);
    tbl[8]  = mk(1, 2, 0, 0, 0, 1, 1, 0, 0);
    tbl[9]  = mk(1, 2, 0, 0, 0, 1, 1, 0, 0);
    tbl[10] = mk(1, 2, 0, 0, 0, 1, 1, 0, 0);
    tbl[11] = mk(1, 2, 1, 0, 0, 1, 1, 0, 0);
    tbl[12] = mk(1, 2, 1, 0, 0, 1, 2, 0, 0);
    tbl[13] = mk(1, 2, 1, 0, 0, 1, 3, 1, 0);
    tbl[14] = mk(0, 2, 0, 1, 0, 0, 0, 0, 0);
    // back-to-back: mat_valid_i held high, second tile all ones
    tbl[15] = mk(1, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[16] = mk(1, 1, 1, 0, 1, 1, 0, 0, 0);
    tbl[17] = mk(1, 1, 1, 0, 0, 1, 1, 0, 0);
    tbl[18] = mk(1, 1, 1, 0, 0, 1, 2, 0, 0);
    tbl[19] = mk(1, 1, 1, 0, 0, 1, 3, 1, 0);
    tbl[20] = mk(1, 1, 1, 1, 0, 0, 0, 0, 0);
    tbl[21] = mk(0, 1, 1, 0, 1, 1, 0, 0, 1);
    tbl[22] = mk(0, 1, 1, 0, 0, 1, 1, 0, 1);
    tbl[23] = mk(0, 1, 1, 0, 0, 1, 2, 0, 1);
    tbl[24] = mk(0, 1, 1, 0, 0, 1, 3, 1, 1);
    tbl[25] = mk(0, 1, 1, 1, 0, 0, 0, 0, 0);
    set_mat(0);
    bus.mat_valid_i = 1'b0;
    bus.row_ready_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset row_valid", 64'(bus.row_valid_o), 64'd0);
    chk("reset busy", 64'(bus.busy_o), 64'd0);
    chk("reset acc_clr", 64'(bus.acc_clr_o), 64'd0);
    chk("reset row_last", 64'(bus.row_last_o), 64'd0);
    chk("reset row_idx", 64'(bus.row_idx_o), 64'd0);
    chk("reset row", bus.row_o, 64'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("post-reset mat_ready", 64'(bus.mat_ready_o), 64'd1);
    step();
    for (int e = 0; e < 26; e++) begin
      bus.mat_valid_i = tbl[e].mv;
      bus.row_ready_i = tbl[e].rdy;
      set_mat(int'(tbl[e].mt));
      #1;
      chk($sformatf("v%0d mat_ready", e), 64'(bus.mat_ready_o), 64'(tbl[e].mrdy));
      chk($sformatf("v%0d acc_clr", e), 64'(bus.acc_clr_o), 64'(tbl[e].clr));
      chk($sformatf("v%0d row_valid", e), 64'(bus.row_valid_o), 64'(tbl[e].v));
      chk($sformatf("v%0d busy", e), 64'(bus.busy_o), 64'(tbl[e].v));
      chk($sformatf("v%0d row_last", e), 64'(bus.row_last_o), 64'(tbl[e].last));
      if (tbl[e].v) begin
        chk($sformatf("v%0d row_idx", e), 64'(bus.row_idx_o), 64'(tbl[e].idx));
        chk($sformatf("v%0d row", e), bus.row_o, exp_row(int'(tbl[e].et), int'(tbl[e].idx)));
      end
      step();
    end
    // async reset between edges while row 2 is presented
    set_mat(0);
    bus.mat_valid_i = 1'b1;
    bus.row_ready_i = 1'b1;
    step();
    bus.mat_valid_i = 1'b0;
    step();
    step();
    chk("mid row_idx", 64'(bus.row_idx_o), 64'd2);
    chk("mid row", bus.row_o, exp_row(0, 2));
    #2 rst = 1'b1;
    #1;
    chk("async row_valid", 64'(bus.row_valid_o), 64'd0);
    chk("async busy", 64'(bus.busy_o), 64'd0);
    chk("async row", bus.row_o, 64'd0);
    chk("async row_idx", 64'(bus.row_idx_o), 64'd0);
    chk("async acc_clr", 64'(bus.acc_clr_o), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("release mat_ready", 64'(bus.mat_ready_o), 64'd1);
    chk("release row_valid", 64'(bus.row_valid_o), 64'd0);
    step();
    chk("idle acc_clr", 64'(bus.acc_clr_o), 64'd0);
    chk("idle row_valid", 64'(bus.row_valid_o), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
